inst_dispatch_ctrl: RTL and testbench

Sequences the graphics instruction stream between the instruction FIFO and the field decoder/raster datapath. It pops one 82-bit instruction word at a time and holds it stable on the decoder input. Alpha-type words are retired internally into a global alpha register. Draw-type words (2- or 3-vertex, solid or texture fill) are issued to the raster engine over a valid/ready handshake, and the block waits for the engine's done pulse before fetching the next word. A watchdog, an instruction counter and a sticky error flag support bring-up.

---
 rtl/inst_dispatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_inst_dispatch_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_dispatch_ctrl
//
// Fetches 82-bit instruction words from the instruction FIFO one at a time and
// holds each on inst_word for the field decoder. Alpha words (bit 0 = 1) are
// retired on the spot into the global alpha register. Draw words are offered
// to the raster engine over draw_valid/draw_ready, and the block then waits
// for the engine's draw_done pulse, guarded by a watchdog, before it fetches
// the next word.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   enable       : allow new fetches (sampled only while idle)
//   fifo_empty   : instruction FIFO empty flag
//   fifo_rdata   : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd      : FIFO pop strobe (one cycle per word)
//   inst_word    : held instruction word for the decoder
//   draw_valid   : draw instruction offered to the raster engine
//   draw_ready   : raster engine accepts the offered instruction
//   draw_done    : raster engine finished (single-cycle pulse)
//   alpha_val    : current global alpha
//   alpha_upd    : one-cycle pulse after an alpha word is retired
//   inst_count   : retired instruction count, saturating
//   busy         : controller is not idle
//   timeout_err  : sticky watchdog-expiry flag
// ---------------------------------------------------------------------------
module inst_dispatch_ctrl #(
  parameter int INST_W  = 82,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [INST_W-1:0] fifo_rdata,
  output logic              fifo_rd,
  output logic [INST_W-1:0] inst_word,
  output logic              draw_valid,
  input  logic              draw_ready,
  input  logic              draw_done,
  output logic [3:0]        alpha_val,
  output logic              alpha_upd,
  output logic [CNT_W-1:0]  inst_count,
  output logic              busy,
  output logic              timeout_err
);

  // The watchdog only has to reach TIMEOUT-1.
  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_ISSUE,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [INST_W-1:0]  inst_word_q, inst_word_d;
  logic [3:0]         alpha_q, alpha_d;
  logic               alpha_upd_q, alpha_upd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_inc;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      inst_word_q <= '0;
      alpha_q     <= 4'hF;
      alpha_upd_q <= 1'b0;
      count_q     <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_word_q <= inst_word_d;
      alpha_q     <= alpha_d;
      alpha_upd_q <= alpha_upd_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_word_d = inst_word_q;
    alpha_d     = alpha_q;
    alpha_upd_d = 1'b0;
    count_d     = count_q;
    wd_d        = wd_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        // enable and the empty flag are only looked at here, so a fetch is
        // only ever started against a FIFO known to hold a word.
        if (enable && !fifo_empty) begin
          state_d = S_POP;
        end
      end

      S_POP: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        inst_word_d = fifo_rdata;
        if (fifo_rdata[0]) begin
          alpha_d     = fifo_rdata[INST_W-1 -: 4];
          alpha_upd_d = 1'b1;
          count_d     = count_inc;
          state_d     = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (draw_ready) begin
          wd_d    = '0;
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        // done is tested first so a done arriving on the last watchdog cycle
        // retires the instruction without flagging an error.
        if (draw_done) begin
          count_d = count_inc;
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the registered state only.
  assign fifo_rd     = (state_q == S_POP);
  assign draw_valid  = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign inst_word   = inst_word_q;
  assign alpha_val   = alpha_q;
  assign alpha_upd   = alpha_upd_q;
  assign inst_count  = count_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for inst_dispatch_ctrl: directed scenarios plus a randomized run
// checked cycle by cycle against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_inst_dispatch_ctrl;

  localparam int INST_W  = 82;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [INST_W-1:0] fifo_rdata = '0;
  logic              fifo_rd;
  logic [INST_W-1:0] inst_word;
  logic              draw_valid;
  logic              draw_ready = 1'b0;
  logic              draw_done = 1'b0;
  logic [3:0]        alpha_val;
  logic              alpha_upd;
  logic [CNT_W-1:0]  inst_count;
  logic              busy;
  logic              timeout_err;

  inst_dispatch_ctrl #(
    .INST_W (INST_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .inst_word  (inst_word),
    .draw_valid (draw_valid),
    .draw_ready (draw_ready),
    .draw_done  (draw_done),
    .alpha_val  (alpha_val),
    .alpha_upd  (alpha_upd),
    .inst_count (inst_count),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // FIFO and raster-engine stand-ins
  logic [INST_W-1:0] fq[$];
  int  underflows = 0;
  int  ready_delay = 0;   // cycles draw_valid is held before ready
  int  done_at = -1;      // wait-cycle index of draw_done, -1 = never
  int  rcnt = 0;
  int  wcnt = 0;
  bit  eng_wait = 0;

  // Reference model: where the current instruction is in its life
  bit  m_idle = 1, m_rd = 0, m_latch = 0, m_issue = 0, m_wait = 0, m_upd = 0;
  int  m_widx = 0;
  logic [INST_W-1:0] e_word = '0;
  logic [3:0]        e_alpha = 4'hF;
  int  e_cnt = 0;
  bit  e_err = 0;

  function automatic logic [INST_W-1:0] rand_word(input bit is_alpha, input logic [3:0] a);
    logic [INST_W-1:0] w;
    w = INST_W'({$urandom(), $urandom(), $urandom()});
    w[0] = is_alpha;
    if (is_alpha) w[INST_W-1 -: 4] = a;
    return w;
  endfunction

  task automatic push_word(input logic [INST_W-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: advance FIFO, engine and reference model; outputs are then
  // stable for sampling (1 time unit after the edge).
  task automatic cycle();
    bit p_en, p_empty, p_ready, p_done, p_rst, p_rd, p_valid;
    bit n_rd, n_latch, n_issue, n_wait;
    logic [INST_W-1:0] p_rdata;
    p_en    = (enable === 1'b1);
    p_empty = (fifo_empty === 1'b1);
    p_ready = (draw_ready === 1'b1);
    p_done  = (draw_done === 1'b1);
    p_rst   = (rst === 1'b1);
    p_rd    = (fifo_rd === 1'b1);
    p_valid = (draw_valid === 1'b1);
    p_rdata = fifo_rdata;
    @(posedge clk);
    #1;
    // FIFO: data appears the cycle after the pop strobe, garbage otherwise
    fifo_rdata = INST_W'({$urandom(), $urandom(), $urandom()});
    if (p_rd) begin
      if (fq.size() == 0) underflows++;
      else fifo_rdata = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
    // Raster engine
    if (p_rst) eng_wait = 0;
    else if (p_valid && p_ready) begin eng_wait = 1; wcnt = 0; end
    else if (eng_wait) wcnt++;
    if (p_done) eng_wait = 0;
    draw_done = eng_wait && (wcnt == done_at);
    if (draw_valid === 1'b1) begin
      draw_ready = (rcnt >= ready_delay);
      rcnt++;
    end else begin
      rcnt = 0;
      draw_ready = 1'($urandom_range(0, 1));
    end
    // Reference model
    if (p_rst) begin
      m_idle = 1; m_rd = 0; m_latch = 0; m_issue = 0; m_wait = 0; m_upd = 0;
      m_widx = 0; e_word = '0; e_alpha = 4'hF; e_cnt = 0; e_err = 0;
    end else begin
      n_rd    = m_idle && p_en && !p_empty;
      n_latch = m_rd;
      n_issue = 0;
      n_wait  = 0;
      m_upd   = 0;
      if (m_latch) begin
        e_word = p_rdata;
        if (p_rdata[0]) begin
          e_alpha = p_rdata[INST_W-1 -: 4];
          m_upd = 1;
          if (e_cnt < CNT_MAX) e_cnt++;
        end else n_issue = 1;
      end
      if (m_issue) begin
        if (p_ready) begin n_wait = 1; m_widx = 0; end
        else n_issue = 1;
      end
      if (m_wait) begin
        if (p_done) begin
          if (e_cnt < CNT_MAX) e_cnt++;
        end else if (m_widx == TIMEOUT - 1) e_err = 1;
        else begin n_wait = 1; m_widx++; end
      end
      m_rd = n_rd; m_latch = n_latch; m_issue = n_issue; m_wait = n_wait;
      m_idle = !(n_rd || n_latch || n_issue || n_wait);
    end
  endtask

  task automatic do_reset();
    fq.delete();
    fifo_empty = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int rd_n;
    enable = 1'b1;
    do_reset();
    checks++; if (alpha_val !== 4'hF) begin failures++; $display("FAIL reset_alpha got=%h exp=F", alpha_val); end
    checks++; if (inst_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", inst_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (inst_word !== '0) begin failures++; $display("FAIL reset_word got=%h exp=0", inst_word); end
    checks++; if ({fifo_rd, draw_valid, alpha_upd, timeout_err} !== 4'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {fifo_rd, draw_valid, alpha_upd, timeout_err});
    end
    rd_n = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (fifo_rd !== 1'b0) rd_n++; end
    checks++; if (rd_n != 0) begin failures++; $display("FAIL idle_empty_pops got=%0d exp=0", rd_n); end
    $display("[tb] reset/idle done");
  endtask

  task automatic test_alpha();
    logic [INST_W-1:0] w;
    int rd_n, rd_at, upd_n, upd_at, busy_n;
    do_reset();
    enable = 1'b1; ready_delay = 0; done_at = -1;
    w = rand_word(1, 4'h6);
    push_word(w);
    rd_n = 0; rd_at = -1; upd_n = 0; upd_at = -1; busy_n = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (fifo_rd === 1'b1) begin rd_n++; if (rd_at < 0) rd_at = i; end
      if (alpha_upd === 1'b1) begin upd_n++; if (upd_at < 0) upd_at = i; end
      if (busy === 1'b1) busy_n++;
    end
    checks++; if (rd_n != 1) begin failures++; $display("FAIL alpha_pops got=%0d exp=1", rd_n); end
    checks++; if (rd_at != 1) begin failures++; $display("FAIL alpha_pop_cycle got=%0d exp=1", rd_at); end
    checks++; if (upd_n != 1) begin failures++; $display("FAIL alpha_upd_pulses got=%0d exp=1", upd_n); end
    checks++; if (upd_at != 3) begin failures++; $display("FAIL alpha_upd_cycle got=%0d exp=3", upd_at); end
    checks++; if (busy_n != 2) begin failures++; $display("FAIL alpha_busy_cycles got=%0d exp=2", busy_n); end
    checks++; if (alpha_val !== 4'h6) begin failures++; $display("FAIL alpha_val got=%h exp=6", alpha_val); end
    checks++; if (inst_count !== 4'd1) begin failures++; $display("FAIL alpha_count got=%0d exp=1", inst_count); end
    checks++; if (inst_word !== w) begin failures++; $display("FAIL alpha_word got=%h exp=%h", inst_word, w); end
    $display("[tb] alpha word retired alpha=%h count=%0d", alpha_val, inst_count);
  endtask

  task automatic test_draw_backpressure();
    logic [INST_W-1:0] w;
    int vis_at, n_valid, acc_at, bad;
    do_reset();
    enable = 1'b1; ready_delay = 5; done_at = 9;
    w = rand_word(0, 4'h0);
    w[1] = 1'b1;
    push_word(w);
    push_word(rand_word(1, 4'h9));
    vis_at = -1;
    for (int i = 1; i <= 10 && vis_at < 0; i++) begin cycle(); if (draw_valid === 1'b1) vis_at = i; end
    checks++; if (vis_at != 3) begin failures++; $display("FAIL draw_valid_cycle got=%0d exp=3", vis_at); end
    n_valid = 0; acc_at = -1; bad = 0;
    while (draw_valid === 1'b1 && n_valid < 20) begin
      n_valid++;
      if (inst_word !== w) bad++;
      if (draw_ready === 1'b1 && acc_at < 0) acc_at = n_valid;
      cycle();
    end
    checks++; if (n_valid != 6) begin failures++; $display("FAIL draw_valid_len got=%0d exp=6", n_valid); end
    checks++; if (acc_at != 6) begin failures++; $display("FAIL draw_accept_cycle got=%0d exp=6", acc_at); end
    checks++; if (bad != 0) begin failures++; $display("FAIL draw_word_stable got=%0d_bad exp=0", bad); end
    for (int k = 1; k <= 9; k++) cycle();
    checks++; if (inst_count !== 4'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL draw_before_done got=cnt%0d,busy%b exp=cnt0,busy1", inst_count, busy);
    end
    cycle();
    checks++; if (inst_count !== 4'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL draw_retire got=cnt%0d,busy%b exp=cnt1,busy0", inst_count, busy);
    end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL draw_no_err got=%b exp=0", timeout_err); end
    cycle();
    checks++; if (fifo_rd !== 1'b1) begin failures++; $display("FAIL draw_next_pop got=%b exp=1", fifo_rd); end
    $display("[tb] draw with backpressure retired count=%0d", inst_count);
  endtask

  task automatic test_back_to_back();
    logic [INST_W-1:0] wd, w3, seen_word;
    logic [3:0] upd_vals[2];
    int n_rd, overlap, n_upd, draw_ord;
    do_reset();
    enable = 1'b1; ready_delay = 0; done_at = 1;
    wd = rand_word(0, 4'h0);
    w3 = rand_word(1, 4'hA);
    push_word(rand_word(1, 4'h3));
    push_word(wd);
    push_word(w3);
    n_rd = 0; overlap = 0; n_upd = 0; draw_ord = -1; seen_word = '0;
    upd_vals[0] = 4'h0; upd_vals[1] = 4'h0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (fifo_rd === 1'b1) n_rd++;
      if (fifo_rd === 1'b1 && draw_valid === 1'b1) overlap++;
      if (alpha_upd === 1'b1) begin if (n_upd < 2) upd_vals[n_upd] = alpha_val; n_upd++; end
      if (draw_valid === 1'b1 && draw_ord < 0) begin draw_ord = n_upd; seen_word = inst_word; end
    end
    checks++; if (n_rd != 3) begin failures++; $display("FAIL b2b_pops got=%0d exp=3", n_rd); end
    checks++; if (overlap != 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
    checks++; if (n_upd != 2 || upd_vals[0] !== 4'h3 || upd_vals[1] !== 4'hA) begin
      failures++; $display("FAIL b2b_alpha_seq got=%0d:%h,%h exp=2:3,A", n_upd, upd_vals[0], upd_vals[1]);
    end
    checks++; if (draw_ord != 1 || seen_word !== wd) begin
      failures++; $display("FAIL b2b_draw_order got=%0d word=%h exp=1 word=%h", draw_ord, seen_word, wd);
    end
    checks++; if (inst_count !== 4'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", inst_count); end
    checks++; if (inst_word !== w3) begin failures++; $display("FAIL b2b_last_word got=%h exp=%h", inst_word, w3); end
    $display("[tb] back-to-back mix retired count=%0d", inst_count);
  endtask

  task automatic run_watchdog(input int d_at, input bit exp_err, input int exp_cnt, input string tag);
    int wcyc, guard;
    do_reset();
    enable = 1'b1; ready_delay = 0; done_at = d_at;
    push_word(rand_word(0, 4'h0));
    push_word(rand_word(1, 4'h4));
    guard = 0;
    while (draw_valid !== 1'b1 && guard < 10) begin cycle(); guard++; end
    while (draw_valid === 1'b1 && guard < 20) begin cycle(); guard++; end
    checks++; if (guard >= 20) begin failures++; $display("FAIL %s_issue_wait got=%0d exp=<20", tag, guard); end
    wcyc = 0;
    while (busy === 1'b1 && wcyc < 40) begin wcyc++; cycle(); end
    checks++; if (wcyc != TIMEOUT) begin failures++; $display("FAIL %s_wait_cycles got=%0d exp=%0d", tag, wcyc, TIMEOUT); end
    checks++; if (timeout_err !== exp_err) begin failures++; $display("FAIL %s_err got=%b exp=%b", tag, timeout_err, exp_err); end
    checks++; if (inst_count !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, inst_count, exp_cnt); end
    cycle();
    checks++; if (fifo_rd !== 1'b1) begin failures++; $display("FAIL %s_next_pop got=%b exp=1", tag, fifo_rd); end
    $display("[tb] watchdog %s err=%b count=%0d", tag, timeout_err, inst_count);
  endtask

  task automatic test_watchdog();
    run_watchdog(-1, 1'b1, 0, "wd_expire");
    run_watchdog(TIMEOUT - 1, 1'b0, 1, "wd_late_done");
  endtask

  task automatic test_reset_mid_issue();
    int guard;
    do_reset();
    enable = 1'b1; ready_delay = 1000; done_at = -1;
    push_word(rand_word(1, 4'h5));
    push_word(rand_word(0, 4'h0));
    guard = 0;
    while (draw_valid !== 1'b1 && guard < 20) begin cycle(); guard++; end
    checks++; if (draw_valid !== 1'b1 || alpha_val !== 4'h5 || inst_count !== 4'd1) begin
      failures++; $display("FAIL rst_issue_setup got=v%b,a%h,c%0d exp=v1,a5,c1", draw_valid, alpha_val, inst_count);
    end
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (draw_valid !== 1'b0 || busy !== 1'b0 || fifo_rd !== 1'b0 || alpha_upd !== 1'b0) begin
      failures++; $display("FAIL rst_issue_strobes got=%b exp=0000", {draw_valid, busy, fifo_rd, alpha_upd});
    end
    checks++; if (inst_word !== '0 || alpha_val !== 4'hF || inst_count !== '0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL rst_issue_regs got=w%h,a%h,c%0d,e%b exp=w0,aF,c0,e0", inst_word, alpha_val, inst_count, timeout_err);
    end
    $display("[tb] reset mid-issue done");
  endtask

  task automatic test_enable_drop();
    int guard, rd_n;
    do_reset();
    enable = 1'b1; ready_delay = 0; done_at = 4;
    push_word(rand_word(0, 4'h0));
    push_word(rand_word(1, 4'h2));
    push_word(rand_word(1, 4'h7));
    guard = 0;
    while (draw_valid !== 1'b1 && guard < 10) begin cycle(); guard++; end
    while (draw_valid === 1'b1 && guard < 20) begin cycle(); guard++; end
    enable = 1'b0;
    rd_n = 0;
    for (int i = 0; i < 30; i++) begin cycle(); if (fifo_rd === 1'b1) rd_n++; end
    checks++; if (rd_n != 0) begin failures++; $display("FAIL en_drop_pops got=%0d exp=0", rd_n); end
    checks++; if (inst_count !== 4'd1 || busy !== 1'b0) begin
      failures++; $display("FAIL en_drop_complete got=c%0d,b%b exp=c1,b0", inst_count, busy);
    end
    enable = 1'b1;
    rd_n = 0;
    for (int i = 0; i < 12; i++) begin cycle(); if (fifo_rd === 1'b1) rd_n++; end
    checks++; if (rd_n != 2 || inst_count !== 4'd3 || alpha_val !== 4'h7) begin
      failures++; $display("FAIL en_resume got=p%0d,c%0d,a%h exp=p2,c3,a7", rd_n, inst_count, alpha_val);
    end
    $display("[tb] enable drop done count=%0d", inst_count);
  endtask

  task automatic test_saturation();
    int wraps;
    logic [CNT_W-1:0] prev;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < CNT_MAX + 2; i++) push_word(rand_word(1, 4'(i + 1)));
    wraps = 0;
    prev = inst_count;
    for (int i = 0; i < 3 * (CNT_MAX + 2) + 6; i++) begin
      cycle();
      if (inst_count < prev) wraps++;
      prev = inst_count;
    end
    checks++; if (inst_count !== CNT_W'(CNT_MAX) || wraps != 0) begin
      failures++; $display("FAIL sat_count got=%0d wraps=%0d exp=%0d wraps=0", inst_count, wraps, CNT_MAX);
    end
    checks++; if (alpha_val !== 4'(CNT_MAX + 2)) begin
      failures++; $display("FAIL sat_alpha got=%h exp=%h", alpha_val, 4'(CNT_MAX + 2));
    end
    $display("[tb] saturation done count=%0d", inst_count);
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1; ready_delay = 1; done_at = 3;
    underflows = 0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 6)
        push_word(rand_word(1'($urandom_range(0, 1)), 4'($urandom())));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) ready_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0)
        done_at = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 3));
      rst = ($urandom_range(0, 399) == 0);
      cycle();
      checks++; if (fifo_rd !== m_rd) begin failures++; $display("FAIL rnd_fifo_rd cyc=%0d got=%b exp=%b", c, fifo_rd, m_rd); end
      checks++; if (draw_valid !== m_issue) begin failures++; $display("FAIL rnd_draw_valid cyc=%0d got=%b exp=%b", c, draw_valid, m_issue); end
      checks++; if (busy !== !m_idle) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, !m_idle); end
      checks++; if (alpha_upd !== m_upd) begin failures++; $display("FAIL rnd_alpha_upd cyc=%0d got=%b exp=%b", c, alpha_upd, m_upd); end
      checks++; if (alpha_val !== e_alpha) begin failures++; $display("FAIL rnd_alpha_val cyc=%0d got=%h exp=%h", c, alpha_val, e_alpha); end
      checks++; if (inst_count !== CNT_W'(e_cnt)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, inst_count, e_cnt); end
      checks++; if (timeout_err !== e_err) begin failures++; $display("FAIL rnd_timeout_err cyc=%0d got=%b exp=%b", c, timeout_err, e_err); end
      checks++; if (inst_word !== e_word) begin failures++; $display("FAIL rnd_inst_word cyc=%0d got=%h exp=%h", c, inst_word, e_word); end
    end
    rst = 1'b0;
    checks++; if (underflows != 0) begin failures++; $display("FAIL rnd_underflow got=%0d exp=0", underflows); end
    $display("[tb] random run done count=%0d", inst_count);
  endtask

  initial begin
    test_reset();
    test_alpha();
    test_draw_backpressure();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_issue();
    test_enable_drop();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
